// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    // Fetch stage controller states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request for pc is being offered to memory
        ST_WAIT  = 2'd1,   // one request outstanding, waiting for the word
        ST_HOLD  = 2'd2,   // buffered instruction presented to decode
        ST_HALT  = 2'd3    // misaligned redirect seen; idle until reset
    } fetch_state_t;

    // Size of one instruction word in bytes
    localparam logic [31:0] c_instr_bytes = 32'd4;

    // PC value used when the top is not told otherwise
    localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pc_reg
// Description : Architectural PC register with reset value, redirect load,
//               wrap-around increment and redirect alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_default_reset_pc,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic            incr,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    logic [XLEN-1:0] r_pc;

    // Load wins over increment; increment wraps naturally at 2^XLEN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= XLEN'(RESET_PC);
        end else if (load) begin
            r_pc <= load_pc;
        end else if (incr) begin
            r_pc <= r_pc + XLEN'(c_instr_bytes);
        end
    end

    // A target is misaligned when it is not on an instruction-word boundary
    always_comb begin
        misaligned = (load_pc[1:0] != 2'b00);
    end

    assign pc = r_pc;

endmodule : instr_fetch_pc_reg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage. Issues one instruction-memory read at a time,
//               buffers the returned word for decode, handles redirects
//               (dropping stale in-flight responses) and halts with a sticky
//               fault on a misaligned redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_default_reset_pc,
    parameter int          XLEN     = 32   // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_addr,
    output logic            fetch_fault
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            r_instr_valid;
    logic [XLEN-1:0] r_instr_out;
    logic [XLEN-1:0] r_instr_addr;
    logic            r_fetch_fault;

    logic            w_pc_load;
    logic            w_pc_incr;
    logic [XLEN-1:0] w_pc;
    logic            w_misaligned;
    logic            w_redir;
    logic            w_buf_load;
    logic            w_buf_clr;
    logic            w_fault_set;

    instr_fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .XLEN     (XLEN)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_pc_load),
        .load_pc    (redirect_pc),
        .incr       (w_pc_incr),
        .pc         (w_pc),
        .misaligned (w_misaligned)
    );

    // State and stale-response flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Next-state logic; an accepted redirect overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        w_pc_load   = 1'b0;
        w_pc_incr   = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clr   = 1'b0;
        w_fault_set = 1'b0;
        w_redir     = redirect && (r_state != ST_HALT);

        if (w_redir) begin
            w_pc_load = 1'b1;
            w_buf_clr = 1'b1;
            if (w_misaligned) begin
                // Any outstanding response is simply ignored in HALT
                w_fault_set = 1'b1;
                w_drop_nxt  = 1'b0;
                w_state_nxt = ST_HALT;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (imem_req_ready) begin
                            // Old-pc request was accepted; its data is stale
                            w_state_nxt = ST_WAIT;
                            w_drop_nxt  = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_resp_valid) begin
                            w_state_nxt = ST_FETCH;
                            w_drop_nxt  = 1'b0;
                        end else begin
                            w_drop_nxt  = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        w_state_nxt = ST_FETCH;
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_req_ready) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_buf_load  = 1'b1;
                            w_pc_incr   = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        w_buf_clr   = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = ST_HALT;
                end
            endcase
        end
    end

    // Output buffer to decode and sticky fault flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_valid <= 1'b0;
            r_instr_out   <= '0;
            r_instr_addr  <= '0;
            r_fetch_fault <= 1'b0;
        end else begin
            if (w_buf_load) begin
                r_instr_out   <= imem_resp_data;
                r_instr_addr  <= w_pc;
                r_instr_valid <= 1'b1;
            end else if (w_buf_clr) begin
                r_instr_valid <= 1'b0;
            end
            if (w_fault_set) begin
                r_fetch_fault <= 1'b1;
            end
        end
    end

    // Request channel is idle while reset is asserted
    always_comb begin
        imem_req_valid = rst_n && (r_state == ST_FETCH);
        imem_req_addr  = w_pc;
    end

    assign instr_valid = r_instr_valid;
    assign instr_out   = r_instr_out;
    assign instr_addr  = r_instr_addr;
    assign fetch_fault = r_fetch_fault;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a transaction-level
//               reference model, directed scenarios and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_ready = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_addr;
    logic        fetch_fault;

    // Second instance checks PC wrap-around from the top of the address space
    logic        wr_resp_valid = 1'b0;
    logic [31:0] wr_resp_data = '0;
    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic        wr_instr_valid;
    logic [31:0] wr_instr_out;
    logic [31:0] wr_instr_addr;
    logic        wr_fault;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_out(instr_out), .instr_addr(instr_addr),
        .fetch_fault(fetch_fault)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(wr_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(wr_req_addr), .imem_resp_valid(wr_resp_valid),
        .imem_resp_data(wr_resp_data), .instr_valid(wr_instr_valid),
        .instr_ready(1'b1), .instr_out(wr_instr_out), .instr_addr(wr_instr_addr),
        .fetch_fault(wr_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: transaction view of the fetch stage
    logic        m_known = 1'b0;
    logic [31:0] m_pc;
    logic        m_busy;     // a request is outstanding at the memory
    logic        m_stale;    // the outstanding response must be thrown away
    logic        m_valid;
    logic [31:0] m_out;
    logic [31:0] m_addr;
    logic        m_fault;
    logic        m_halt;

    // Memory model: at most one request in flight
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic        wr_pend = 1'b0;

    logic [31:0] req_q[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] wreq_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic exp_req();
        return rst_n && m_known && !m_halt && !m_busy && !m_valid;
    endfunction

    function automatic void compare();
        if (!m_known) return;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req()));
        if (exp_req()) chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr_out", instr_out, m_out);
        chk("instr_addr", instr_addr, m_addr);
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    endfunction

    function automatic void model_update();
        logic hs;
        logic acc;
        if (!rst_n) begin
            m_known = 1'b1; m_pc = 32'h0; m_busy = 1'b0; m_stale = 1'b0;
            m_valid = 1'b0; m_out = '0; m_addr = '0; m_fault = 1'b0; m_halt = 1'b0;
            return;
        end
        if (!m_known) return;
        hs  = exp_req() && imem_req_ready;
        acc = m_valid && instr_ready;
        if (m_halt) begin
            if (imem_resp_valid) m_busy = 1'b0;
        end else if (redirect) begin
            if (hs) m_busy = 1'b1;
            if (imem_resp_valid) m_busy = 1'b0;
            m_stale = m_busy;
            m_pc    = redirect_pc;
            m_valid = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_halt  = 1'b1;
            end
        end else begin
            if (hs) m_busy = 1'b1;
            if (imem_resp_valid) begin
                m_busy = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_out   = imem_resp_data;
                    m_addr  = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                end
            end
            if (acc) m_valid = 1'b0;
        end
    endfunction

    // One clock cycle: drive memory and inputs, compare, advance the model
    task automatic step(input logic rn, input logic rd, input logic [31:0] rpc,
                        input logic qr, input logic ir, input int lat);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mem_addr);
            end
        end
        wr_resp_valid = wr_pend;
        wr_resp_data  = wr_pend ? mem_word(wr_req_addr) : 32'h0;
        wr_pend       = 1'b0;
        rst_n          = rn;
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = qr;
        instr_ready    = ir;
        #1;
        compare();
        if (rn && instr_valid && instr_ready) begin
            acc_addr.push_back(instr_addr);
            acc_cyc.push_back(cyc);
        end
        if (rn && imem_req_valid && imem_req_ready) begin
            req_q.push_back(imem_req_addr);
            mem_addr = imem_req_addr;
            mem_cnt  = lat;
        end
        if (!rn) mem_cnt = 0;
        if (rn && wr_req_valid) begin
            wreq_q.push_back(wr_req_addr);
            wr_pend = 1'b1;
        end
        model_update();
        cyc++;
    endtask

    task automatic wait_accept(input int bound);
        int n0 = acc_addr.size();
        int k  = 0;
        while (acc_addr.size() == n0 && k < bound) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
            k++;
        end
        chk("accept_timeout", 32'(acc_addr.size() > n0), 32'd1);
    endtask

    initial begin
        int          k;
        int          nreq;
        int          nacc;
        int          halt_cnt;
        logic [31:0] a;
        logic [31:0] rpc;
        logic        rn;

        // Reset, then single-cycle memory with decode always ready
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        k = 0;
        while (acc_addr.size() < 3 && k < 30) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
            k++;
        end
        chk("seq_count", acc_addr.size(), 32'd3);
        if (acc_addr.size() >= 3) begin
            chk("seq_addr0", acc_addr[0], 32'h0);
            chk("seq_addr1", acc_addr[1], 32'h4);
            chk("seq_addr2", acc_addr[2], 32'h8);
            chk("seq_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("seq_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        chk("seq_data0", 32'(req_q.size() >= 3 ? req_q[2] : 32'hDEAD), 32'h8);
        chk("wrap_count", 32'(wreq_q.size() >= 2), 32'd1);
        if (wreq_q.size() >= 2) begin
            chk("wrap_req0", wreq_q[0], 32'hFFFF_FFFC);
            chk("wrap_req1", wreq_q[1], 32'h0000_0000);
        end
        chk("wrap_fault", 32'(wr_fault), 32'd0);

        // Decode stall while holding the word at 0xC
        k = 0;
        do begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1);
            k++;
        end while (!instr_valid && k < 10);
        a = instr_addr;
        chk("stall_addr", a, 32'hC);
        chk("stall_data", instr_out, mem_word(32'hC));
        nreq = req_q.size();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1);
            chk("stall_stable", instr_addr, a);
            chk("stall_noreq", req_q.size(), nreq);
        end

        // Redirect to 0x100 while waiting on a slow response
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);      // accept 0xC
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3);      // request 0x10
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1);    // redirect in WAIT
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);      // stale response returns
        chk("redir_valid_low", 32'(instr_valid), 32'd0);
        wait_accept(20);
        chk("redir_prev_req", req_q[req_q.size()-2], 32'h10);
        chk("redir_req", req_q[$], 32'h100);
        chk("redir_addr", acc_addr[$], 32'h100);

        // Redirect to 0x200 in the same cycle as the response
        nacc = acc_addr.size();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2);      // request 0x104
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1);    // response + redirect
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        chk("same_cyc_no_valid", 32'(instr_valid), 32'd0);
        chk("same_cyc_req", imem_req_addr, 32'h200);
        wait_accept(20);
        chk("same_cyc_addr", acc_addr[$], 32'h200);
        chk("same_cyc_count", acc_addr.size(), nacc + 1);

        // Misaligned redirect halts with a sticky fault until reset
        step(1'b1, 1'b1, 32'h102, 1'b0, 1'b1, 1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_noreq", 32'(imem_req_valid), 32'd0);
        nreq = req_q.size();
        step(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
            chk("halt_fault", 32'(fetch_fault), 32'd1);
            chk("halt_noreq", req_q.size(), nreq);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        chk("fault_cleared", 32'(fetch_fault), 32'd0);
        wait_accept(20);
        chk("restart_addr", acc_addr[$], 32'h0);

        // Random traffic against the model
        halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            halt_cnt = m_halt ? halt_cnt + 1 : 0;
            rn = !(($urandom_range(0, 299) == 0) || (halt_cnt > 4));
            rpc = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF8;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(rn, ($urandom_range(0, 11) == 0), rpc,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
